// File: rtl/fault_injector_ctrl.sv
// rtl/fault_injector_ctrl.sv - register-file fault injection campaign controller
module fault_injector_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int ADDRW = $clog2(DEPTH),
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ADDRW-1:0] cfg_addr,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic [1:0]       cfg_type,
  input  logic [CNTW-1:0]  cfg_delay,
  input  logic [CNTW-1:0]  cfg_duration,
  input  logic             cfg_permanent,
  input  logic             cfg_rand,
  input  logic             abort,
  output logic             fault_enable,
  output logic [ADDRW-1:0] fault_addr,
  output logic [WIDTH-1:0] fault_mask,
  output logic [1:0]       fault_type,
  output logic             busy,
  output logic             done,
  output logic [CNTW-1:0]  inject_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ACTIVE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [31:0] LFSR_SEED = 32'hACE10001;
  // Right-shifting Galois taps for x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  state_t            state_q;
  logic [CNTW-1:0]   cnt_q;
  logic [ADDRW-1:0]  addr_l_q;
  logic [WIDTH-1:0]  mask_l_q;
  logic [1:0]        type_l_q;
  logic [CNTW-1:0]   dur_l_q;
  logic              perm_l_q;
  logic              rand_l_q;
  logic [31:0]       lfsr_q;
  logic [31:0]       lfsr_d;

  logic              accept;
  logic [WIDTH-1:0]  entry_mask;
  logic [CNTW-1:0]   active_len;

  // Outputs of the FSM are registered, so cfg_ready itself gates acceptance
  assign accept     = cfg_valid && cfg_ready;
  assign entry_mask = rand_l_q ? (lfsr_q[WIDTH-1:0] & mask_l_q) : mask_l_q;
  // A zero duration still produces one active cycle
  assign active_len = (dur_l_q == '0) ? '0 : dur_l_q - 1'b1;

  // Next LFSR value: shift right, fold taps in when the outgoing bit is set
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[31:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_TAPS;
    end
  end

  // Free-running pattern source for randomised masks
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Campaign FSM with all outputs registered; abort overrides everything
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_l_q     <= '0;
      mask_l_q     <= '0;
      type_l_q     <= '0;
      dur_l_q      <= '0;
      perm_l_q     <= 1'b0;
      rand_l_q     <= 1'b0;
      cfg_ready    <= 1'b0;
      fault_enable <= 1'b0;
      fault_addr   <= '0;
      fault_mask   <= '0;
      fault_type   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      inject_count <= '0;
    end else if (abort) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cfg_ready    <= 1'b1;
      fault_enable <= 1'b0;
      fault_addr   <= '0;
      fault_mask   <= '0;
      fault_type   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            addr_l_q <= cfg_addr;
            mask_l_q <= cfg_mask;
            type_l_q <= cfg_type;
            dur_l_q  <= cfg_duration;
            perm_l_q <= cfg_permanent;
            rand_l_q <= cfg_rand;
            if (cfg_type == 2'd0) begin
              // Nothing to inject: complete immediately
              state_q   <= S_DONE;
              done      <= 1'b1;
              cfg_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state_q   <= S_ARMED;
              cnt_q     <= cfg_delay;
              cfg_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end else begin
            state_q   <= S_IDLE;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        S_ARMED: begin
          if (cnt_q == '0) begin
            state_q      <= S_ACTIVE;
            cnt_q        <= active_len;
            fault_enable <= 1'b1;
            fault_addr   <= addr_l_q;
            fault_mask   <= entry_mask;
            fault_type   <= type_l_q;
            if (inject_count != {CNTW{1'b1}}) begin
              inject_count <= inject_count + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_ACTIVE: begin
          if (!perm_l_q) begin
            if (cnt_q == '0) begin
              state_q      <= S_DONE;
              fault_enable <= 1'b0;
              fault_addr   <= '0;
              fault_mask   <= '0;
              fault_type   <= '0;
              done         <= 1'b1;
              cfg_ready    <= 1'b1;
              busy         <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fault_injector_ctrl.sv
// tb/tb_fault_injector_ctrl.sv - directed vector bench for fault_injector_ctrl
module tb_fault_injector_ctrl;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int ADDRW = 5;
  localparam int CNTW  = 4;

  logic             clk;
  logic             rst_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [ADDRW-1:0] cfg_addr;
  logic [WIDTH-1:0] cfg_mask;
  logic [1:0]       cfg_type;
  logic [CNTW-1:0]  cfg_delay;
  logic [CNTW-1:0]  cfg_duration;
  logic             cfg_permanent;
  logic             cfg_rand;
  logic             abort;
  logic             fault_enable;
  logic [ADDRW-1:0] fault_addr;
  logic [WIDTH-1:0] fault_mask;
  logic [1:0]       fault_type;
  logic             busy;
  logic             done;
  logic [CNTW-1:0]  inject_count;

  fault_injector_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDRW(ADDRW), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_type(cfg_type),
    .cfg_delay(cfg_delay), .cfg_duration(cfg_duration),
    .cfg_permanent(cfg_permanent), .cfg_rand(cfg_rand), .abort(abort),
    .fault_enable(fault_enable), .fault_addr(fault_addr),
    .fault_mask(fault_mask), .fault_type(fault_type), .busy(busy),
    .done(done), .inject_count(inject_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDRW-1:0] addr;
    logic [31:0]      mask;
    logic [1:0]       typ;
    logic [CNTW-1:0]  dly;
    logic [CNTW-1:0]  dur;
    logic             rnd;
    int               e_start;
    int               e_len;
    int               e_done;
    logic [31:0]      e_mask;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_inj  = 0;

  // Reference LFSR: value before the most recent edge and after it
  logic [31:0] lfsr_m;
  logic [31:0] lfsr_prev;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    logic [31:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  always @(posedge clk) begin
    lfsr_prev = lfsr_m;
    if (!rst_n) lfsr_m = 32'hACE10001;
    else        lfsr_m = lfsr_step(lfsr_m);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_inj();
    if (exp_inj < 15) exp_inj++;
  endtask

  task automatic drive_cfg(input logic [ADDRW-1:0] a, input logic [31:0] m, input logic [1:0] t,
                           input logic [CNTW-1:0] d, input logic [CNTW-1:0] du,
                           input logic p, input logic r);
    cfg_addr = a; cfg_mask = m; cfg_type = t; cfg_delay = d;
    cfg_duration = du; cfg_permanent = p; cfg_rand = r;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int first_en = -1;
    int en_len = 0;
    int first_done = -1;
    int done_cnt = 0;
    int bad = 0;
    logic busy0 = 1'b0;
    logic [31:0] mask_seen = '0;
    logic [31:0] addr_seen = '0;
    logic [31:0] type_seen = '0;
    logic [31:0] rmask = '0;
    check($sformatf("v%0d_ready_before", idx), {31'b0, cfg_ready}, 32'd1);
    drive_cfg(v.addr, v.mask, v.typ, v.dly, v.dur, 1'b0, v.rnd);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    drive_cfg(~v.addr, ~v.mask, ~v.typ, ~v.dly, ~v.dur, 1'b1, ~v.rnd);
    for (int k = 0; k < v.e_done + 4; k++) begin
      if (k == 0) busy0 = busy;
      if (fault_enable) begin
        if (first_en < 0) begin
          first_en  = k;
          mask_seen = fault_mask;
          addr_seen = {27'b0, fault_addr};
          type_seen = {30'b0, fault_type};
          rmask     = lfsr_prev & v.mask;
        end else if (fault_mask !== mask_seen) begin
          bad++;
        end
        en_len++;
      end else if (fault_addr != '0 || fault_mask != '0 || fault_type != '0) begin
        bad++;
      end
      if (done) begin
        if (first_done < 0) first_done = k;
        done_cnt++;
      end
      step();
    end
    if (v.typ != 2'd0) bump_inj();
    check($sformatf("v%0d_en_start", idx), first_en, v.e_start);
    check($sformatf("v%0d_en_len", idx), en_len, v.e_len);
    check($sformatf("v%0d_done_idx", idx), first_done, v.e_done);
    check($sformatf("v%0d_done_cnt", idx), done_cnt, 1);
    check($sformatf("v%0d_busy0", idx), {31'b0, busy0}, (v.typ != 2'd0) ? 32'd1 : 32'd0);
    check($sformatf("v%0d_idle_zero_const", idx), bad, 0);
    check($sformatf("v%0d_inject_count", idx), {28'b0, inject_count}, exp_inj);
    if (v.e_start >= 0) begin
      check($sformatf("v%0d_mask", idx), mask_seen, v.rnd ? rmask : v.e_mask);
      check($sformatf("v%0d_addr", idx), addr_seen, {27'b0, v.addr});
      check($sformatf("v%0d_type", idx), type_seen, {30'b0, v.typ});
    end
  endtask

  function automatic vec_t mk(input logic [ADDRW-1:0] a, input logic [31:0] m, input logic [1:0] t,
                              input logic [CNTW-1:0] d, input logic [CNTW-1:0] du, input logic r,
                              input int es, input int el, input int ed, input logic [31:0] em);
    vec_t v;
    v.addr = a; v.mask = m; v.typ = t; v.dly = d; v.dur = du; v.rnd = r;
    v.e_start = es; v.e_len = el; v.e_done = ed; v.e_mask = em;
    return v;
  endfunction

  vec_t vecs[5];

  initial begin
    int en_bits;
    int done_bits;
    int cnt;
    logic [31:0] a3;
    logic [31:0] a8;

    vecs[0] = mk(5'd5, 32'h0000_0001, 2'd1, 4'd3, 4'd2, 1'b0, 4, 2, 6, 32'h0000_0001);
    vecs[1] = mk(5'd9, 32'h0000_FF00, 2'd3, 4'd0, 4'd0, 1'b0, 1, 1, 2, 32'h0000_FF00);
    vecs[2] = mk(5'd3, 32'h0000_00FF, 2'd0, 4'd2, 4'd2, 1'b0, -1, 0, 0, 32'h0);
    vecs[3] = mk(5'd0, 32'hFFFF_FFFF, 2'd2, 4'd2, 4'd3, 1'b0, 3, 3, 6, 32'hFFFF_FFFF);
    vecs[4] = mk(5'd7, 32'hF0F0_F0F0, 2'd1, 4'd1, 4'd1, 1'b1, 2, 1, 3, 32'h0);

    rst_n = 1'b0; cfg_valid = 1'b0; abort = 1'b0;
    drive_cfg('0, '0, '0, '0, '0, 1'b0, 1'b0);

    // Reset state
    repeat (3) step();
    check("rst_ready", {31'b0, cfg_ready}, 32'd0);
    check("rst_enable", {31'b0, fault_enable}, 32'd0);
    check("rst_busy_done", {30'b0, busy, done}, 32'd0);
    check("rst_inject", {28'b0, inject_count}, 32'd0);
    check("rst_fault_fields", {25'b0, fault_addr, fault_type} | fault_mask, 32'd0);
    rst_n = 1'b1;
    step();
    check("release_ready", {31'b0, cfg_ready}, 32'd1);

    // Table-driven campaigns
    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Back-to-back with cfg_valid held high
    drive_cfg(5'd4, 32'h3C, 2'd1, 4'd2, 4'd1, 1'b0, 1'b0);
    cfg_valid = 1'b1;
    step();
    en_bits = 0; done_bits = 0; a3 = '0; a8 = '0;
    for (int k = 0; k < 13; k++) begin
      if (k == 1) cfg_addr = 5'd6;
      if (fault_enable) en_bits |= (1 << k);
      if (done) done_bits |= (1 << k);
      if (k == 3) a3 = {27'b0, fault_addr};
      if (k == 8) a8 = {27'b0, fault_addr};
      if (k == 5) cfg_valid = 1'b0;
      step();
    end
    bump_inj(); bump_inj();
    check("b2b_enable_pattern", en_bits, (1 << 3) | (1 << 8));
    check("b2b_done_pattern", done_bits, (1 << 4) | (1 << 9));
    check("b2b_first_addr", a3, 32'd4);
    check("b2b_second_addr", a8, 32'd6);
    check("b2b_inject", {28'b0, inject_count}, exp_inj);

    // Permanent fault ended by abort
    drive_cfg(5'd2, 32'hF, 2'd2, 4'd0, 4'd1, 1'b1, 1'b0);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (fault_enable) cnt++;
    end
    bump_inj();
    check("perm_enable_cycles", cnt, 10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("perm_abort_enable", {31'b0, fault_enable}, 32'd0);
    check("perm_abort_mask", fault_mask, 32'd0);
    check("perm_abort_state", {29'b0, busy, done, cfg_ready}, 32'd1);
    step();
    check("perm_abort_no_done", {31'b0, done}, 32'd0);
    check("perm_inject", {28'b0, inject_count}, exp_inj);

    // Abort while armed: fault never fires
    drive_cfg(5'd8, 32'h1, 2'd1, 4'd5, 4'd1, 1'b0, 1'b0);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (fault_enable || done || busy) cnt++;
      step();
    end
    check("armed_abort_quiet", cnt, 0);
    check("armed_abort_inject", {28'b0, inject_count}, exp_inj);

    // Saturation of inject_count
    for (int n = 0; n < 10; n++) begin
      drive_cfg(5'd1, 32'h1, 2'd1, 4'd0, 4'd0, 1'b0, 1'b0);
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      repeat (3) step();
      bump_inj();
    end
    check("inject_saturate", {28'b0, inject_count}, 32'd15);

    // Reset during an active permanent fault
    drive_cfg(5'd12, 32'hFFFF_FFFF, 2'd3, 4'd0, 4'd0, 1'b1, 1'b0);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    check("rst_mid_pre_enable", {31'b0, fault_enable}, 32'd1);
    check("rst_mid_pre_mask", fault_mask, 32'hFFFF_FFFF);
    rst_n = 1'b0;
    step();
    check("rst_mid_enable", {31'b0, fault_enable}, 32'd0);
    check("rst_mid_fields", {25'b0, fault_addr, fault_type} | fault_mask, 32'd0);
    check("rst_mid_flags", {29'b0, busy, done, cfg_ready}, 32'd0);
    check("rst_mid_inject", {28'b0, inject_count}, 32'd0);
    rst_n = 1'b1;
    step();
    check("rst_mid_release_ready", {31'b0, cfg_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
